// File: rtl/fractal_pkg.sv
// Shared fractal-pipeline types: coordinate format, tile width and scanner state encoding.
package fractal_pkg;
  localparam int EFMSB  = 18;
  localparam int TILE_W = 64;

  typedef logic signed [EFMSB:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Multiply by an elaboration-time constant; unrolls to a shift-add tree.
  function automatic coord_t mul_const(coord_t x, int unsigned k);
    coord_t acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction
endpackage

// File: rtl/viewport_scanner.sv
// Walks a frame tile by tile, emitting the complex-plane origin, step and row coordinate
// of each 64-pixel tile to the coordinate tree under a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for frame_start; centre and step latched on the request
//   SETUP | origin computed from latched centre/step, position cleared
//   EMIT  | tile descriptor valid, advances on each accepted transfer
//   DONE  | one-cycle frame_done pulse before returning to IDLE
module viewport_scanner
  import fractal_pkg::*;
#(
  parameter int TILES_PER_ROW = 10,
  parameter int ROWS          = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic signed [18:0] center_re,
  input  logic signed [18:0] center_im,
  input  logic signed [18:0] step,
  input  logic               ready,
  output logic               valid,
  output logic signed [18:0] left,
  output logic signed [18:0] mul,
  output logic signed [18:0] im,
  output logic [3:0]         tile_x,
  output logic [8:0]         row_y,
  output logic               last_tile,
  output logic               busy,
  output logic               frame_done
);
  localparam int unsigned HALF_W_PIX = TILES_PER_ROW * (TILE_W / 2);
  localparam int unsigned HALF_ROWS  = ROWS / 2;

  scan_state_t state, state_nx;
  coord_t cre_q, cim_q, origin_re;
  coord_t origin_re_c, origin_im_c, tile_step;
  logic   at_row_end, at_last_row;

  assign origin_re_c = cre_q - mul_const(mul, HALF_W_PIX);
  assign origin_im_c = cim_q - mul_const(mul, HALF_ROWS);
  assign tile_step   = mul << $clog2(TILE_W);

  assign at_row_end  = (tile_x == 4'(TILES_PER_ROW - 1));
  assign at_last_row = (row_y == 9'(ROWS - 1));

  assign valid      = (state == EMIT);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign last_tile  = valid && at_row_end && at_last_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = SETUP;
      SETUP:   state_nx = EMIT;
      EMIT:    if (ready && last_tile) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cre_q     <= '0;
      cim_q     <= '0;
      origin_re <= '0;
      mul       <= '0;
      left      <= '0;
      im        <= '0;
      tile_x    <= '0;
      row_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            cre_q <= center_re;
            cim_q <= center_im;
            mul   <= step;
          end
        end
        SETUP: begin
          origin_re <= origin_re_c;
          left      <= origin_re_c;
          im        <= origin_im_c;
          tile_x    <= '0;
          row_y     <= '0;
        end
        EMIT: begin
          if (ready) begin
            if (!at_row_end) begin
              tile_x <= tile_x + 4'd1;
              left   <= left + tile_step;
            end else if (!at_last_row) begin
              tile_x <= '0;
              left   <= origin_re;
              im     <= im + mul;
              row_y  <= row_y + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/viewport_scanner.md
VIEWPORT_SCANNER -- requirements
Module: viewport_scanner

Interface
REQ-001 Parameter TILES_PER_ROW, default 10; number of 64-pixel tiles per screen row.
REQ-002 Parameter ROWS, default 480; number of screen rows per frame.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle request to begin a frame scan.
REQ-006 center_re  input  19  signed real coordinate of the screen centre.
REQ-007 center_im  input  19  signed imaginary coordinate of the screen centre.
REQ-008 step  input  19  signed per-pixel coordinate increment.
REQ-009 ready  input  1  downstream accepts the current tile when high with valid.
REQ-010 valid  output  1  tile descriptor on outputs is valid.
REQ-011 left  output  19  signed real coordinate of pixel 0 of the tile; feeds the 64-wide coordinate tree.
REQ-012 mul  output  19  signed per-pixel step for the tile; equals the latched step.
REQ-013 im  output  19  signed imaginary coordinate of the current row.
REQ-014 tile_x  output  4  tile index within the row, 0..TILES_PER_ROW-1.
REQ-015 row_y  output  9  row index, 0..ROWS-1.
REQ-016 last_tile  output  1  high with valid on the final tile of the frame.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 frame_done  output  1  one-cycle pulse after the final tile is accepted.

Function
REQ-019 FSM states: IDLE, SETUP, EMIT, DONE.
REQ-020 IDLE: frame_start=1 latches center_re, center_im and step, then goes to SETUP; otherwise stays.
REQ-021 SETUP (one cycle): origin_re = center_re - (TILES_PER_ROW*32)*step, origin_im = center_im - (ROWS/2)*step; left<=origin_re, im<=origin_im, tile_x<=0, row_y<=0; goes to EMIT.
REQ-022 Constant multiplies are implemented as shift-add; no general multiplier.
REQ-023 Latency: frame_start in cycle N gives valid=1 in cycle N+2.
REQ-024 EMIT: valid=1; left, mul, im, tile_x, row_y and last_tile are held stable while ready=0.
REQ-025 Transfer: a tile is accepted when valid&&ready; at most one tile per cycle, with no bubble between tiles.
REQ-026 On transfer with tile_x<TILES_PER_ROW-1: tile_x+1, left += 64*step.
REQ-027 On transfer at row end with row_y<ROWS-1: tile_x<=0, left<=origin_re, im += step, row_y+1.
REQ-028 On transfer of the final tile (last_tile=1): go to DONE.
REQ-029 DONE (one cycle): frame_done=1, valid=0; then go to IDLE.
REQ-030 All coordinate arithmetic is 19-bit two's complement and wraps modulo 2^19, with no saturation.
REQ-031 frame_start outside IDLE is ignored, and the latched parameters are not altered.
REQ-032 Input changes on center_re, center_im or step after the latch have no effect until the next frame.

Reset
REQ-033 Reset forces IDLE asynchronously, including mid-frame.
REQ-034 During reset, valid, last_tile, busy and frame_done are 0, and left, mul, im, tile_x and row_y are 0.
REQ-035 After reset release, no output activity occurs until frame_start.

Structure
REQ-036 Shared package fractal_pkg holds: EFMSB=18; coord_t (signed [EFMSB:0]); TILE_W=64; the scanner state enum.
REQ-037 Single flat module with no sub-module; origin and step accumulation are inline.

Verification
REQ-038 center_re=0, center_im=0, step=1, ready=1 -> first tile left=-320, im=-240, mul=1; tile 1 left=-256; tile 9 left=256; row 1 tile 0 left=-320, im=-239.
REQ-039 Same frame run to completion -> exactly 4800 transfers; final tile (9,479) has left=256, im=239, last_tile=1; frame_done pulses once, one cycle later.
REQ-040 Backpressure: ready low for 5 cycles on tile 3 -> all outputs unchanged for those cycles; tile 3 transfers exactly once.
REQ-041 Wrap: center_re=262143, step=1 -> tile 0 left=261823; tile 9 left=-261889.
REQ-042 Reset asserted during tile 37 -> valid and busy drop immediately; after release the block stays idle until frame_start; the next frame starts at tile (0,0).
REQ-043 frame_start pulsed during EMIT with a different step -> ignored; mul is unchanged and the sequence is uninterrupted.
